cart_ram_upload_reader: RTL

//   Read-side counterpart of the cartridge download path: services HPS upload

---
 rtl/cart_ram_upload_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cart_ram_upload_reader.sv
// Services HPS upload reads by stealing single RAM cycles from the CPU and
// returning the byte at BASE+offset; offsets beyond the window read as 8'hFF.
//
// state | meaning
// IDLE  | no fetch in flight, RAM port released
// ARB   | cpu_wait raised, waiting for the CPU to leave the RAM
// READ  | reader owns the RAM port, counting read latency
// DONE  | byte presented on ioctl_din_o, din_valid_o pulses
module cart_ram_upload_reader #(
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = 'hC000,
    parameter logic [ADDR_W-1:0] LEN    = 'h4000,
    parameter int                RD_LAT = 1
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              ioctl_upload_i,
    input  logic              ioctl_rd_i,
    input  logic [24:0]       ioctl_addr_i,
    output logic [7:0]        ioctl_din_o,
    output logic              din_valid_o,
    input  logic              cpu_busy_i,
    output logic              cpu_wait_o,
    output logic              mem_sel_o,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic [7:0]        mem_q_i,
    output logic              upload_done_o,
    output logic [ADDR_W-1:0] bytes_read_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {IDLE, ARB, READ, DONE} state_t;

    localparam logic [24:0] LEN_EXT  = 25'(LEN);
    localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic              pend_q, pend_d;
    logic [24:0]       pend_off_q, pend_off_d;
    logic [1:0]        lat_q, lat_d;
    logic [7:0]        din_q, din_d;
    logic [ADDR_W-1:0] bytes_q, bytes_d;
    logic              overrun_q, overrun_d;
    logic              upload_q;
    logic              upload_done_q;

    logic        rd_req;
    logic        can_start;
    logic        start_req;
    logic [24:0] start_off;

    assign rd_req    = ioctl_rd_i & ioctl_upload_i;
    assign can_start = (state_q == IDLE) || (state_q == DONE);
    assign start_req = (pend_q | rd_req) & ioctl_upload_i;
    assign start_off = pend_q ? pend_off_q : ioctl_addr_i;

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            off_q         <= '0;
            pend_q        <= 1'b0;
            pend_off_q    <= '0;
            lat_q         <= '0;
            din_q         <= 8'h00;
            bytes_q       <= '0;
            overrun_q     <= 1'b0;
            upload_q      <= 1'b0;
            upload_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            pend_q        <= pend_d;
            pend_off_q    <= pend_off_d;
            lat_q         <= lat_d;
            din_q         <= din_d;
            bytes_q       <= bytes_d;
            overrun_q     <= overrun_d;
            upload_q      <= ioctl_upload_i;
            upload_done_q <= upload_q & ~ioctl_upload_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        pend_d     = pend_q;
        pend_off_d = pend_off_q;
        lat_d      = lat_q;
        din_d      = din_q;
        bytes_d    = bytes_q;
        overrun_d  = overrun_q;

        // Requests arriving mid-fetch go to the single pending slot.
        if (rd_req && !can_start) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_off_d = ioctl_addr_i;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    bytes_d = bytes_q + ADDR_W'(1);
                end
                state_d = IDLE;
                if (start_req) begin
                    off_d = start_off[ADDR_W-1:0];
                    // Consuming the slot frees it for a request in this cycle.
                    if (pend_q) begin
                        pend_d = rd_req;
                        if (rd_req) begin
                            pend_off_d = ioctl_addr_i;
                        end
                    end
                    if (start_off >= LEN_EXT) begin
                        state_d = DONE;
                        din_d   = 8'hFF;
                    end else begin
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                if (!cpu_busy_i) begin
                    state_d = READ;
                    lat_d   = LAT_INIT;
                end
            end
            READ: begin
                if (lat_q == 2'd0) begin
                    din_d   = mem_q_i;
                    state_d = DONE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!ioctl_upload_i) begin
            pend_d = 1'b0;
            din_d  = din_q;
            if (state_q == ARB || state_q == READ) begin
                state_d = IDLE;
            end
        end

        if (ioctl_upload_i && !upload_q) begin
            bytes_d   = '0;
            overrun_d = 1'b0;
        end
    end

    assign ioctl_din_o   = din_q;
    assign din_valid_o   = (state_q == DONE);
    assign cpu_wait_o    = (state_q == ARB) || (state_q == READ);
    assign mem_sel_o     = (state_q == READ);
    assign mem_a_o       = (state_q == READ) ? (BASE + off_q) : '0;
    assign upload_done_o = upload_done_q;
    assign bytes_read_o  = bytes_q;
    assign overrun_o     = overrun_q;

endmodule
